ffre_bank: RTL and testbench
============================

FFRE_BANK -- requirements
Module: ffre_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (1..64).
REQ-002 SHALL have parameter CHANS, default 4, independent channels (1..16).
REQ-003 SHALL have parameter DEPTH, default 2, register stages per channel (1..8).
REQ-004 SHALL have parameter ENA_POL, default 1, enable polarity (1 = active-high, 0 = active-low).
REQ-005 SHALL have port: clk  in  1  single rising-edge clock for all state.
REQ-006 SHALL have port: clr  in  1  asynchronous active-low reset (asserts at once, releases synchronously to clk).
REQ-007 SHALL have port: ena  in  CHANS  per-channel shift enable, polarity per ENA_POL.
REQ-008 SHALL have port: sclr  in  CHANS  per-channel synchronous clear, active-high.
REQ-009 SHALL have port: d  in  CHANS*WIDTH  channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port: q  out  CHANS*WIDTH  last-stage data per channel, same packing as d.
REQ-011 SHALL have port: vld  out  CHANS  channel pipeline holds DEPTH valid loads.
REQ-012 SHALL have port: par  out  CHANS  even parity of each channel's q.

Function
REQ-013 SHALL build each channel as a DEPTH-stage shift register, stage 0 loading d, last stage driving q.
REQ-014 SHALL advance every stage of channel i on a clk edge only when ena[i] is at its active level (after ENA_POL); otherwise all stages hold.
REQ-015 SHALL give latency of exactly DEPTH enabled edges from d to q; disabled cycles add no latency.
REQ-016 SHALL keep a per-channel fill counter, ceil(log2(DEPTH+1)) bits: +1 on each enabled edge, saturating at DEPTH.
REQ-017 SHALL drive vld[i] high when the fill counter of channel i equals DEPTH, else low.
REQ-018 SHALL, on sclr[i] high at a clk edge, zero all stages and the fill counter of channel i; sclr beats ena on the same edge.
REQ-019 SHALL make channels fully independent; sclr or ena on one channel never affects another.
REQ-020 SHALL, for DEPTH=1, make q a single enabled flop and assert vld after one enabled edge.
REQ-021 SHALL make all outputs registered, with no combinational path from d, ena or sclr to any output.

Reset
REQ-022 SHALL, while clr is low, force every stage, counter, q, vld and par to 0 asynchronously.
REQ-023 SHALL, when clr asserts mid-fill, discard all data and restart the fill count at 0 after release.
REQ-024 SHALL ignore ena and sclr on the first clk edge after clr deasserts only if the release synchronizer requires it; otherwise the first edge is active.

Configuration
REQ-025 SHALL, with macro FFRE_BANK_PARITY_EN defined, register par[i] as the XOR of the data entering the last stage, so par tracks q cycle-exact (0 under sclr and reset).
REQ-026 SHALL, without FFRE_BANK_PARITY_EN, tie par to all zeros and generate no parity flops.

Structure
REQ-027 SHALL place the parameter limits, the counter-width function and the ENA_POL encoding constants in shared package ffre_pkg.
REQ-028 SHALL implement one channel as sub-module ffre_chan (WIDTH, DEPTH, ENA_POL), instantiated CHANS times by a generate loop.
REQ-029 SHALL reject out-of-range parameters at elaboration.

Verification (WIDTH=8, CHANS=4, DEPTH=2, ENA_POL=1 unless stated)
REQ-030 SHALL cover: clr low, then high; ena[0]=1 with d ch0 = 0x11, then 0x22 -> q ch0 = 0x11 and vld[0]=1 after the 2nd edge; vld[3:1]=0.
REQ-031 SHALL cover: ch1 loads 0xA5 with ena[1] toggling 1,0,0,1 -> q ch1 = 0xA5 only after the 2nd enabled edge, held across the disabled cycles.
REQ-032 SHALL cover: ch2 full (vld[2]=1), sclr[2]=1 with ena[2]=1 -> next edge q ch2 = 0 and vld[2]=0; ch0, ch1, ch3 unchanged.
REQ-033 SHALL cover: clr pulsed low between clock edges with ch3 half-filled -> q=0 and vld=0 immediately; 2 enabled edges are needed before vld[3]=1 again.
REQ-034 SHALL cover: ENA_POL=0 with ena[0]=0 for 2 edges -> data shifts; ena[0]=1 -> data holds.
REQ-035 SHALL cover: FFRE_BANK_PARITY_EN defined, q ch0 = 0x07 -> par[0]=1, q ch0 = 0x03 -> par[0]=0; undefined -> par=0 always.

Source files
------------

// File: rtl/ffre_pkg.sv
// Shared limits, enable-polarity encodings and the fill-counter width helper
// used by the ffre_bank shift-register bank and its channel module.
package ffre_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int CHANS_MIN = 1;
  localparam int CHANS_MAX = 16;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 8;

  localparam int ENA_POL_LOW  = 0;
  localparam int ENA_POL_HIGH = 1;

  // Bits needed to count 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ffre_chan.sv
// One channel: DEPTH-stage enabled shift register with saturating fill count.
// Registered parity of q only when FFRE_BANK_PARITY_EN is defined.
module ffre_chan
  import ffre_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 2,
  parameter int ENA_POL = ENA_POL_HIGH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ena,
  input  logic             sclr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld,
  output logic             par
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("ffre_chan: WIDTH out of range");
  end
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("ffre_chan: DEPTH out of range");
  end
  if (ENA_POL != ENA_POL_LOW && ENA_POL != ENA_POL_HIGH) begin : g_bad_pol
    $error("ffre_chan: ENA_POL must be 0 or 1");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             en_act;

  assign en_act = (ENA_POL == ENA_POL_HIGH) ? ena : ~ena;

  // sclr wins over the enable on the same edge.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (sclr) begin
      for (int s = 0; s < DEPTH; s++) stage_d[s] = '0;
      cnt_d = '0;
    end else if (en_act) begin
      stage_d[0] = d;
      for (int s = 1; s < DEPTH; s++) stage_d[s] = stage_q[s-1];
      if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
    end
    vld_d = (cnt_d == FULL);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= stage_d[s];
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign q   = stage_q[DEPTH-1];
  assign vld = vld_q;

`ifdef FFRE_BANK_PARITY_EN
  logic par_q, par_d;

  // Parity of the value about to enter the last stage keeps par aligned with q.
  assign par_d = ^stage_d[DEPTH-1];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) par_q <= 1'b0;
    else      par_q <= par_d;
  end

  assign par = par_q;
`else
  assign par = 1'b0;
`endif

endmodule

// File: rtl/ffre_bank.sv
// Bank of CHANS independent enabled shift-register channels (ffre_chan).
// Optional registered parity output enabled by macro FFRE_BANK_PARITY_EN.
module ffre_bank
  import ffre_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CHANS   = 4,
  parameter int DEPTH   = 2,
  parameter int ENA_POL = ENA_POL_HIGH
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [CHANS-1:0]       ena,
  input  logic [CHANS-1:0]       sclr,
  input  logic [CHANS*WIDTH-1:0] d,
  output logic [CHANS*WIDTH-1:0] q,
  output logic [CHANS-1:0]       vld,
  output logic [CHANS-1:0]       par
);

  if (CHANS < CHANS_MIN || CHANS > CHANS_MAX) begin : g_bad_chans
    $error("ffre_bank: CHANS out of range");
  end

  for (genvar i = 0; i < CHANS; i++) begin : g_chan
    ffre_chan #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ENA_POL (ENA_POL)
    ) u_chan (
      .clk  (clk),
      .clr  (clr),
      .ena  (ena[i]),
      .sclr (sclr[i]),
      .d    (d[i*WIDTH +: WIDTH]),
      .q    (q[i*WIDTH +: WIDTH]),
      .vld  (vld[i]),
      .par  (par[i])
    );
  end

endmodule

// File: tb/tb_ffre_bank.sv
// Scoreboard bench for ffre_bank: random and directed stimulus against a
// load-history reference model; a second instance exercises active-low enable.
module tb_ffre_bank;

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int DEP = 2;

  typedef struct {
    logic [CH*W-1:0] q;
    logic [CH-1:0]   vld;
    logic [CH-1:0]   par;
  } exp_t;

  logic            clk = 1'b0;
  logic            clr;
  logic [CH-1:0]   ena, sclr;
  logic [CH*W-1:0] d, q;
  logic [CH-1:0]   vld, par;

  logic            ena_n, sclr_n;
  logic [W-1:0]    d_n, q_n;
  logic            vld_n, par_n;

  int total = 0;
  int bad   = 0;

  exp_t       sb[$];
  logic [W-1:0] loads [CH][$];

  always #5 clk = ~clk;

  ffre_bank #(.WIDTH(W), .CHANS(CH), .DEPTH(DEP), .ENA_POL(1)) dut (
    .clk(clk), .clr(clr), .ena(ena), .sclr(sclr), .d(d),
    .q(q), .vld(vld), .par(par)
  );

  ffre_bank #(.WIDTH(W), .CHANS(1), .DEPTH(DEP), .ENA_POL(0)) dut_n (
    .clk(clk), .clr(clr), .ena(ena_n), .sclr(sclr_n), .d(d_n),
    .q(q_n), .vld(vld_n), .par(par_n)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Each channel remembers only its loads since the last clear; q is the
  // value loaded DEP enabled edges ago, or zero if fewer loads happened.
  function automatic void model_clear_all();
    for (int c = 0; c < CH; c++) loads[c].delete();
  endfunction

  function automatic void model_apply(input logic [CH-1:0] e, input logic [CH-1:0] s,
                                      input logic [CH*W-1:0] dv);
    for (int c = 0; c < CH; c++) begin
      if (s[c]) loads[c].delete();
      else if (e[c]) begin
        loads[c].push_back(dv[c*W +: W]);
        if (loads[c].size() > DEP) void'(loads[c].pop_front());
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t r;
    r.q = '0; r.vld = '0; r.par = '0;
    for (int c = 0; c < CH; c++) begin
      if (loads[c].size() == DEP) begin
        r.q[c*W +: W] = loads[c][0];
        r.vld[c] = 1'b1;
      end
`ifdef FFRE_BANK_PARITY_EN
      r.par[c] = ^r.q[c*W +: W];
`endif
    end
    return r;
  endfunction

  task automatic step(input logic [CH-1:0] e, input logic [CH-1:0] s, input logic [CH*W-1:0] dv);
    @(negedge clk);
    ena = e; sclr = s; d = dv;
    @(posedge clk);
    model_apply(e, s, dv);
    sb.push_back(model_out());
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("q", 64'(q), 64'(e.q));
      chk("vld", 64'(vld), 64'(e.vld));
      chk("par", 64'(par), 64'(e.par));
    end
  end

  initial begin
    clr = 1'b0; ena = '0; sclr = '0; d = '0;
    ena_n = 1'b1; sclr_n = 1'b0; d_n = '0;
    model_clear_all();
    #3;
    chk("reset_q", 64'(q), 64'd0);
    chk("reset_vld", 64'(vld), 64'd0);
    chk("reset_par", 64'(par), 64'd0);
    @(negedge clk);
    clr = 1'b1;

    // ch0 fill: q=0x11 and vld[0] after second edge
    step(4'b0001, 4'b0000, 32'h0000_0011);
    step(4'b0001, 4'b0000, 32'h0000_0022);
    // ch1 with enable gaps
    step(4'b0010, 4'b0000, 32'h0000_A500);
    step(4'b0000, 4'b0000, 32'h0000_FF00);
    step(4'b0000, 4'b0000, 32'h0000_EE00);
    step(4'b0010, 4'b0000, 32'h0000_5A00);
    // ch2 fill then sclr with ena on same edge
    step(4'b0100, 4'b0000, 32'h0033_0000);
    step(4'b0100, 4'b0000, 32'h0044_0000);
    step(4'b0100, 4'b0100, 32'h0055_0000);
    // ch0 parity patterns
    step(4'b0001, 4'b0000, 32'h0000_0007);
    step(4'b0001, 4'b0000, 32'h0000_0003);
    step(4'b0001, 4'b0000, 32'h0000_0003);
    // ch3 half filled, then async clear between edges
    step(4'b1000, 4'b0000, 32'h6600_0000);
    @(negedge clk);
    ena = '0; sclr = '0;
    #1 clr = 1'b0;
    #1;
    chk("clr_q", 64'(q), 64'd0);
    chk("clr_vld", 64'(vld), 64'd0);
    chk("clr_par", 64'(par), 64'd0);
    model_clear_all();
    #1 clr = 1'b1;
    step(4'b1000, 4'b0000, 32'h7700_0000);
    step(4'b1000, 4'b0000, 32'h8800_0000);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [CH-1:0] e, s;
      e = CH'($urandom);
      s = '0;
      for (int c = 0; c < CH; c++) s[c] = ($urandom_range(0, 7) == 0);
      step(e, s, CH*W'($urandom));
    end

    // active-low enable instance
    @(negedge clk);
    ena = '0; sclr = '0;
    ena_n = 1'b0; d_n = 8'h3C;
    @(negedge clk);
    d_n = 8'h3C;
    @(negedge clk);
    chk("pol0_shift_q", 64'(q_n), 64'h3C);
    chk("pol0_shift_vld", 64'(vld_n), 64'd1);
    ena_n = 1'b1; d_n = 8'h99;
    @(negedge clk);
    @(negedge clk);
    chk("pol0_hold_q", 64'(q_n), 64'h3C);
    ena_n = 1'b0;
    @(negedge clk);
    ena_n = 1'b1;
    @(negedge clk);
    chk("pol0_advance_q", 64'(q_n), 64'h3C);
    ena_n = 1'b0;
    @(negedge clk);
    ena_n = 1'b1;
    chk("pol0_second_q", 64'(q_n), 64'h99);
`ifdef FFRE_BANK_PARITY_EN
    chk("pol0_par", 64'(par_n), 64'd0);
`else
    chk("pol0_par_off", 64'(par_n), 64'd0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
